// File: rtl/instr_mem_pkg.sv
// Shared constants and address-checking helper for the loadable LEGv8 instruction memory.
package instr_mem_pkg;

   localparam logic [31:0] LEGV8_NOP = 32'hD503201F;

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // word is the already-shifted word index; lsb are the raw low address bits.
   function automatic logic addr_fault(input logic [31:0] word,
                                       input logic [1:0]  lsb,
                                       input logic        byte_mode,
                                       input int unsigned depth);
      return (word >= depth) || (byte_mode && (lsb != 2'b00));
   endfunction

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x DATA_W storage with one registered read port and one write port; a read
// and a write to the same word in one cycle returns the old contents.
module instr_mem_array #(
   parameter int DEPTH  = 256,
   parameter int DATA_W = 32,
   parameter int IDX_W  = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      if (re)
         rdata <= mem[raddr];
   end

endmodule

// File: rtl/instr_mem.sv
// Loadable instruction memory: NOP fill after reset, registered fetch with stall hold,
// host load port, and range/alignment fault flagging. ADDR_W must not exceed 32.
module instr_mem
   import instr_mem_pkg::*;
#(
   parameter int               DATA_W    = 32,
   parameter int               ADDR_W    = 16,
   parameter int               DEPTH     = 256,
   parameter int               BYTE_ADDR = 1,
   parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(LEGV8_NOP)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_ready,
   output logic              fetch_valid,
   input  logic              fetch_stall,
   output logic [DATA_W-1:0] fetch_data,
   output logic              fetch_fault,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ready,
   output logic              init_done
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [0:0]        state_reg;
   logic [IDX_W-1:0]  init_ptr_reg;
   logic              valid_reg;
   logic              fault_reg;
   logic              use_ram_reg;

   logic              run;
   logic [ADDR_W-1:0] fetch_word, load_word;
   logic [IDX_W-1:0]  fetch_idx, load_idx;
   logic              fetch_bad, load_bad;
   logic              fetch_accept, load_accept;
   logic              ram_we, ram_re;
   logic [IDX_W-1:0]  ram_waddr;
   logic [DATA_W-1:0] ram_wdata, ram_rdata;

   assign run = (state_reg == ST_RUN);

   always_comb begin
      fetch_word = (BYTE_ADDR != 0) ? (fetch_addr >> 2) : fetch_addr;
      load_word  = (BYTE_ADDR != 0) ? (load_addr >> 2)  : load_addr;
      fetch_idx  = fetch_word[IDX_W-1:0];
      load_idx   = load_word[IDX_W-1:0];
      fetch_bad  = addr_fault(32'(fetch_word), fetch_addr[1:0], BYTE_ADDR != 0, DEPTH);
      load_bad   = addr_fault(32'(load_word), load_addr[1:0], BYTE_ADDR != 0, DEPTH);
   end

   assign fetch_ready  = run & ~(valid_reg & fetch_stall);
   assign fetch_accept = fetch_req & fetch_ready;
   assign load_ready   = run;
   assign load_accept  = load_en & run & ~load_bad;
   assign init_done    = run;

   // The write port belongs to the NOP fill during INIT and to the host afterwards.
   assign ram_we    = ~run | load_accept;
   assign ram_waddr = run ? load_idx : init_ptr_reg;
   assign ram_wdata = run ? load_data : FILL_WORD;
   assign ram_re    = fetch_accept & ~fetch_bad;

   instr_mem_array #(
      .DEPTH (DEPTH),
      .DATA_W(DATA_W),
      .IDX_W (IDX_W)
   ) u_array (
      .clk  (clk),
      .we   (ram_we),
      .waddr(ram_waddr),
      .wdata(ram_wdata),
      .re   (ram_re),
      .raddr(fetch_idx),
      .rdata(ram_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_INIT;
         init_ptr_reg <= '0;
      end else if (state_reg == ST_INIT) begin
         init_ptr_reg <= init_ptr_reg + IDX_W'(1);
         if (init_ptr_reg == IDX_W'(DEPTH - 1))
            state_reg <= ST_RUN;
      end
   end

   // The RAM read register only moves on an accepted good fetch, so it also
   // serves as the held data; use_ram_reg picks it over FILL_WORD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg   <= 1'b0;
         fault_reg   <= 1'b0;
         use_ram_reg <= 1'b0;
      end else if (!(valid_reg & fetch_stall)) begin
         if (fetch_accept) begin
            valid_reg   <= 1'b1;
            fault_reg   <= fetch_bad;
            use_ram_reg <= ~fetch_bad;
         end else begin
            valid_reg   <= 1'b0;
         end
      end
   end

   assign fetch_valid = valid_reg;
   assign fetch_fault = fault_reg;
   assign fetch_data  = use_ram_reg ? ram_rdata : FILL_WORD;

endmodule
